// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between uart_rx_fifo and its neighbours.
// The producer/consumer side drives the master modport, and the buffer takes the slave modport.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] wr_data;
  logic              wr_valid;
  logic              flush;
  logic              clr_ovf;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic [LW-1:0]     level;
  logic              empty;
  logic              full;
  logic              almost_full;
  logic              overflow;

  modport master (
    output wr_data, wr_valid, flush, clr_ovf, m_ready,
    input  m_data, m_valid, level, empty, full, almost_full, overflow
  );

  modport slave (
    input  wr_data, wr_valid, flush, clr_ovf, m_ready,
    output m_data, m_valid, level, empty, full, almost_full, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side byte buffer behind uart_rx: it writes on the rising edge of valid and reads out first-word-fall-through.
// Status is taken from the pointers, so no input reaches an output without passing through a register.
module uart_rx_fifo #(
  parameter int DATA_W       = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_THRESH = 12
) (
  input  logic           rx_clk,
  input  logic           rx_rst_n,
  uart_rx_fifo_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] PTR_ONE   = PW'(1);
  localparam logic [PW-1:0] AFULL_LVL = PW'(AFULL_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic          wrValid_q;
  logic          ovf_q, ovf_d;

  logic          push;
  logic          pop;
  logic          accept;
  logic          dropped;
  logic          isEmpty;
  logic          isFull;
  logic [PW-1:0] levelNow;

  assign isEmpty  = (wrPtr_q == rdPtr_q);
  assign isFull   = (wrPtr_q[AW] != rdPtr_q[AW]) &&
                    (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign levelNow = wrPtr_q - rdPtr_q;

  // A valid signal held high produces only one capture, so only the 0->1 transition counts.
  assign push    = bus.wr_valid & ~wrValid_q;
  assign pop     = ~isEmpty & bus.m_ready;
  assign accept  = push & (~isFull | pop) & ~bus.flush;
  assign dropped = push & isFull & ~pop & ~bus.flush;

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    ovf_d   = ovf_q;
    if (bus.flush) begin
      wrPtr_d = '0;
      rdPtr_d = '0;
    end else begin
      if (accept) wrPtr_d = wrPtr_q + PTR_ONE;
      if (pop)    rdPtr_d = rdPtr_q + PTR_ONE;
    end
    if (dropped)          ovf_d = 1'b1;
    else if (bus.clr_ovf) ovf_d = 1'b0;
  end

  always_ff @(posedge rx_clk or negedge rx_rst_n) begin
    if (!rx_rst_n) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      wrValid_q <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      wrValid_q <= bus.wr_valid;
      ovf_q     <= ovf_d;
    end
  end

  // When the buffer is full, a push that comes with a pop reuses the slot that the pop is leaving.
  always_ff @(posedge rx_clk) begin
    if (accept) mem[wrPtr_q[AW-1:0]] <= bus.wr_data;
  end

  assign bus.m_valid     = ~isEmpty;
  assign bus.m_data      = isEmpty ? '0 : mem[rdPtr_q[AW-1:0]];
  assign bus.level       = levelNow;
  assign bus.empty       = isEmpty;
  assign bus.full        = isFull;
  assign bus.almost_full = (levelNow >= AFULL_LVL);
  assign bus.overflow    = ovf_q;
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo.
// A queue-based model of the buffer contents predicts every output, and directed steps plus random traffic drive the design.
module tb_uart_rx_fifo;
  localparam int DATA_W       = 8;
  localparam int DEPTH        = 16;
  localparam int AFULL_THRESH = 12;

  logic rx_clk   = 1'b0;
  logic rx_rst_n = 1'b0;

  uart_rx_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  uart_rx_fifo #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AFULL_THRESH(AFULL_THRESH)
  ) dut (
    .rx_clk  (rx_clk),
    .rx_rst_n(rx_rst_n),
    .bus     (bus)
  );

  always #5 rx_clk = ~rx_clk;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] modelQ[$];
  bit         modelOvf;
  bit         modelWvPrev;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    int lvl;
    lvl = modelQ.size();
    checkOutput({tag, ".m_valid"}, 32'(bus.m_valid), 32'(lvl != 0));
    checkOutput({tag, ".m_data"}, 32'(bus.m_data), (lvl != 0) ? 32'(modelQ[0]) : 32'd0);
    checkOutput({tag, ".level"}, 32'(bus.level), 32'(lvl));
    checkOutput({tag, ".empty"}, 32'(bus.empty), 32'(lvl == 0));
    checkOutput({tag, ".full"}, 32'(bus.full), 32'(lvl == DEPTH));
    checkOutput({tag, ".almost_full"}, 32'(bus.almost_full), 32'(lvl >= AFULL_THRESH));
    checkOutput({tag, ".overflow"}, 32'(bus.overflow), 32'(modelOvf));
  endtask

  task automatic modelReset();
    modelQ.delete();
    modelOvf    = 1'b0;
    modelWvPrev = 1'b1;
  endtask

  // Drive one cycle's inputs, advance the model by one clock edge, and return at the following falling edge.
  task automatic applyStimulus(input bit wv, input logic [7:0] wd, input bit rdy,
                               input bit fl, input bit co);
    bit push, pop, setOvf;
    bus.wr_valid = wv;
    bus.wr_data  = wd;
    bus.m_ready  = rdy;
    bus.flush    = fl;
    bus.clr_ovf  = co;
    push   = wv && !modelWvPrev;
    pop    = rdy && (modelQ.size() > 0);
    setOvf = 1'b0;
    modelWvPrev = wv;
    if (fl) begin
      modelQ.delete();
    end else begin
      if (pop) void'(modelQ.pop_front());
      if (push) begin
        if (modelQ.size() < DEPTH) modelQ.push_back(wd);
        else setOvf = 1'b1;
      end
    end
    if (setOvf)  modelOvf = 1'b1;
    else if (co) modelOvf = 1'b0;
    @(negedge rx_clk);
  endtask

  task automatic pushByte(input logic [7:0] b);
    applyStimulus(1'b1, b, 1'b0, 1'b0, 1'b0);
    checkAll("push");
    applyStimulus(1'b0, b, 1'b0, 1'b0, 1'b0);
    checkAll("pushIdle");
  endtask

  task automatic drainAll();
    while (modelQ.size() > 0) begin
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkAll("drain");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bus.wr_valid = 1'b1;
    bus.wr_data  = 8'h3C;
    bus.m_ready  = 1'b0;
    bus.flush    = 1'b0;
    bus.clr_ovf  = 1'b0;
    modelReset();
    repeat (3) @(negedge rx_clk);
    rx_rst_n = 1'b1;
    checkAll("reset");

    // A valid that is already high when reset is released must not be captured.
    applyStimulus(1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkAll("heldAtRelease");
    applyStimulus(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    checkAll("idle");

    applyStimulus(1'b1, 8'hCE, 1'b0, 1'b0, 1'b0);
    checkAll("singlePush");
    checkOutput("singlePush.const", 32'(bus.m_data), 32'h0000_00CE);
    applyStimulus(1'b0, 8'hCE, 1'b1, 1'b0, 1'b0);
    checkAll("singlePop");
    checkOutput("singlePop.emptyConst", 32'(bus.empty), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
      checkAll("levelHeld");
    end
    checkOutput("levelHeld.levelConst", 32'(bus.level), 32'd1);
    applyStimulus(1'b0, 8'hAA, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    checkAll("reRaise");
    checkOutput("reRaise.levelConst", 32'(bus.level), 32'd2);
    applyStimulus(1'b0, 8'h55, 1'b0, 1'b0, 1'b0);
    checkOutput("order.first", 32'(bus.m_data), 32'h0000_00AA);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkOutput("order.second", 32'(bus.m_data), 32'h0000_0055);
    drainAll();

    for (int i = 0; i < 16; i++) pushByte(8'(i));
    checkOutput("fill.fullConst", 32'(bus.full), 32'd1);
    pushByte(8'hFF);
    checkOutput("fill.ovfConst", 32'(bus.overflow), 32'd1);
    checkOutput("fill.levelConst", 32'(bus.level), 32'd16);
    for (int i = 0; i < 16; i++) begin
      checkOutput("drainOrder", 32'(bus.m_data), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkAll("drainFill");
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkAll("clrOvf");

    for (int i = 0; i < 16; i++) pushByte(8'(i));
    applyStimulus(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    checkAll("pushPopFull");
    checkOutput("pushPopFull.levelConst", 32'(bus.level), 32'd16);
    checkOutput("pushPopFull.ovfConst", 32'(bus.overflow), 32'd0);
    for (int i = 1; i < 16; i++) begin
      checkOutput("wrapOrder", 32'(bus.m_data), 32'(i));
      applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checkAll("wrapDrain");
    end
    checkOutput("wrapOrder.last", 32'(bus.m_data), 32'h0000_0077);
    drainAll();

    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                    1'b0, 1'b0);
      checkAll("rand");
    end
    drainAll();

    for (int i = 0; i < 16; i++) pushByte(8'(8'h20 + i));
    pushByte(8'hEE);
    for (int i = 0; i < 11; i++) applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("preFlush.levelConst", 32'(bus.level), 32'd5);
    applyStimulus(1'b1, 8'h99, 1'b1, 1'b1, 1'b0);
    checkAll("flush");
    checkOutput("flush.levelConst", 32'(bus.level), 32'd0);
    checkOutput("flush.ovfConst", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkAll("clrAfterFlush");

    for (int i = 0; i < 16; i++) pushByte(8'(8'h40 + i));
    pushByte(8'hEE);
    applyStimulus(1'b1, 8'hDD, 1'b0, 1'b0, 1'b1);
    checkAll("setWins");
    checkOutput("setWins.ovfConst", 32'(bus.overflow), 32'd1);
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checkAll("clrAlone");
    drainAll();

    for (int i = 0; i < 6; i++) pushByte(8'(8'h60 + i));
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    checkAll("midDrain");
    #2;
    rx_rst_n = 1'b0;
    modelReset();
    #1;
    checkAll("asyncReset");
    checkOutput("asyncReset.levelConst", 32'(bus.level), 32'd0);
    @(negedge rx_clk);
    rx_rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checkAll("afterReset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side byte buffer directly downstream of uart_rx, in the rx_clk domain.
- Captures each byte presented on uart_rx's rx_o_data / rx_o_data_valid pair and holds it in a DEPTH-entry circular buffer.
- Presents buffered bytes to the consumer (bus interface / host logic) through a first-word-fall-through valid/ready port, with fill-level and sticky overflow status.

Parameters:
- DATA_W, 8, byte width; matches uart_rx rx_o_data.
- DEPTH, 16, number of entries; must be a power of 2, >= 2.
- AFULL_THRESH, 12, level at or above which almost_full asserts; 1..DEPTH.

Ports:
- rx_clk  in  1  receiver clock, shared with uart_rx.
- rx_rst_n  in  1  asynchronous active-low reset.
- wr_data  in  DATA_W  byte from uart_rx rx_o_data.
- wr_valid  in  1  uart_rx rx_o_data_valid; pulse or level-held.
- flush  in  1  synchronous buffer clear.
- clr_ovf  in  1  synchronous clear of overflow flag.
- m_data  out  DATA_W  head-of-buffer byte.
- m_valid  out  1  m_data holds a buffered byte.
- m_ready  in  1  consumer accepts m_data.
- level  out  $clog2(DEPTH)+1  entries currently stored, 0..DEPTH.
- empty  out  1  level == 0.
- full  out  1  level == DEPTH.
- almost_full  out  1  level >= AFULL_THRESH.
- overflow  out  1  sticky: a byte was dropped.

Behaviour:
- Clock and reset: one clock, rx_clk; reset is asynchronous and active-low (rx_rst_n).
- Reset values: wr/rd pointers 0, level 0, empty 1, full 0, almost_full 0, overflow 0, m_valid 0, m_data 0, wr_valid_q 1. Storage array is not reset.
- Write strobe:
  - push = wr_valid & ~wr_valid_q, where wr_valid_q is wr_valid registered each cycle.
  - A level-held valid produces exactly one push; a valid already high at reset release is not captured.
  - wr_data is sampled in the push cycle.
- Pop: pop = m_valid & m_ready.
- Pointers: $clog2(DEPTH)+1 bits each, wrap naturally. Memory index = low bits. full = MSBs differ and low bits equal; empty = pointers equal.
- FWFT: m_valid = ~empty; m_data = mem[rd_ptr low bits] when m_valid, else 0.
  - Latency: a byte pushed at rising edge N is on m_data with m_valid=1 from edge N onward; it can be popped at edge N+1 at the earliest.
- level, empty, full and almost_full are registered or pointer-derived; all reflect state after each edge.
- Push and pop in the same cycle:
  - Non-empty and not full: both occur, level unchanged.
  - Full: both occur (the pop frees the slot), level stays DEPTH, no overflow.
  - Empty: pop cannot occur (m_valid=0); the push is accepted.
- Overflow: push while full without a simultaneous pop drops the byte (storage and pointers unchanged) and sets overflow=1.
- overflow is sticky until clr_ovf. If clr_ovf and a new overflow occur in the same cycle, set wins.
- flush:
  - Next edge: both pointers reset to 0, level 0, m_valid 0.
  - overflow is unaffected.
  - A push in the same cycle is discarded and not counted as overflow; a pop in the same cycle is ignored.
  - wr_valid_q still updates.
- Asserting rx_rst_n low mid-operation clears everything immediately (asynchronously) to the reset values.
- Implementation: no combinational path from wr_valid or wr_data to any output.

Test Plan:
- Reset, then wr_valid pulse with 0xCE, m_ready=0: next cycle m_valid=1, m_data=0xCE, level=1, empty=0. Raise m_ready one cycle: m_valid=0, empty=1, level=0.
- Hold wr_valid high for 20 cycles with 0xAA: exactly one entry stored, level=1. Drop and re-raise wr_valid with 0x55: level=2, read order 0xAA then 0x55.
- Push 16 distinct bytes 0x00..0x0F with m_ready=0:
  - almost_full rises when level reaches 12; full=1 at level 16.
  - 17th push (0xFF) sets overflow=1, level stays 16.
  - Draining yields 0x00..0x0F in order; 0xFF is never output.
- Fill to 16, then push 0x77 with m_ready=1 in the same cycle: 0x00 popped, 0x77 stored, overflow stays 0, level stays 16. Full drain ends with 0x77.
- Over 3 full wrap cycles (48+ bytes) with random m_ready:
  - Output order matches push order.
  - level always equals pushes minus pops.
- Controls and reset:
  - With level=5 and overflow=1, assert flush: level=0, m_valid=0, overflow still 1.
  - Assert clr_ovf and an overflowing push in the same cycle: overflow stays 1.
  - Assert rx_rst_n low mid-drain: all outputs return to reset values without waiting for a clock edge.
